midi_voice_allocator: RTL and testbench
=======================================

# midi_voice_allocator

Polyphonic voice scheduler between the MIDI receive path and the synth voice bank. It accepts note-on and note-off events and assigns each sounding note to one of NUM_VOICES voice slots: it reuses a free slot, retriggers a slot already holding the same note, or steals the oldest slot when all are busy. Per-voice note, velocity, gate and a one-cycle retrigger strobe drive the oscillator/envelope voices directly.

## Interface
- NUM_VOICES, 8, number of voice slots; power of two, 2..16.
- VW, $clog2(NUM_VOICES), slot index / age width (derived, not overridable).
- clk  input  1  system clock (50 MHz); all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- evt_valid  input  1  event present; held until accepted.
- evt_ready  output  1  allocator can accept; transfer when evt_valid && evt_ready.
- evt_note_on  input  1  1 = note on, 0 = note off.
- evt_note  input  7  MIDI note number.
- evt_velocity  input  7  MIDI velocity; note-on with velocity 0 is treated as note-off.
- panic  input  1  all-notes-off; single-cycle pulse or level.
- voice_gate  output  NUM_VOICES  slot sounding.
- voice_trig  output  NUM_VOICES  one-cycle strobe on slot (re)start.
- voice_note  output  7*NUM_VOICES  note per slot; slot i at [7i+6:7i].
- voice_velocity  output  7*NUM_VOICES  velocity per slot, same packing.
- steal_pulse  output  1  one-cycle strobe when an allocation stole a busy slot.

## Operation
- FSM states: IDLE, LOOKUP, COMMIT.
- IDLE: evt_ready=1. On transfer, latch note, velocity and effective type (note_on && velocity!=0) -> LOOKUP.
- LOOKUP: evt_ready=0. Register match_hit/match_idx (lowest active slot with voice_note==latched note), free_hit/free_idx (lowest inactive slot), oldest_idx (active slot with age NUM_VOICES-1) -> COMMIT.
- COMMIT: evt_ready=0. Apply the action below -> IDLE.
- Note-on target: match_idx if match_hit (retrigger), else free_idx if free_hit, else oldest_idx (steal, pulse steal_pulse). Write note and velocity, set gate, pulse voice_trig for the target.
- Note-off: if match_hit, clear gate of match_idx; note and velocity keep their values. If there is no match, no state change.
- Age tracking: each slot has a VW-bit age. Active ages are always exactly 0..k-1, where k is the number of active slots.
  - Allocating into a free slot: all active slots age +1; target age = 0.
  - Retrigger/steal of slot with age a: active slots with age < a get +1; target age = 0.
  - Release of slot with age a: active slots with age > a get -1.
- panic: in the cycle it is seen, clear all gates and ages, abort any in-flight event (dropped), go to IDLE. No voice_trig. Takes priority over COMMIT in the same cycle.
- Duplicate note-off and note-off for an unassigned note are harmless no-ops.

## Timing
- Reset (rst_n=0 at posedge): state=IDLE, evt_ready=1, voice_gate=0, voice_trig=0, steal_pulse=0, voice_note=0, voice_velocity=0, all ages=0. Reset mid-event discards the event.
- Throughput: one event per 3 cycles. Transfer at edge T; voice outputs updated at edge T+2; voice_trig/steal_pulse high during cycle T+2..T+3 only; evt_ready high again after edge T+2.
- Event at 31.25 kbaud arrives far less often than every 3 cycles; no input buffering required.
- All outputs registered; no combinational path from evt_* to outputs.

## Structure
- Package midi_pkg: evt_type_t enum (EVT_NOTE_OFF, EVT_NOTE_ON), alloc_state_t enum (IDLE, LOOKUP, COMMIT), note_t/vel_t 7-bit typedefs. Share with the MIDI receiver.
- Sub-module voice_search: combinational priority/match search, parameterized by NUM_VOICES. Inputs: gates, notes, ages, key. Outputs: match_hit/idx, free_hit/idx, oldest_idx. Registered by the parent in LOOKUP.

## Test plan
- Reset, then note-on 60 vel 100 -> slot 0 gate=1, note=60, vel=100, voice_trig[0] pulse at T+2; evt_ready low exactly 2 cycles.
- Note-ons 60,62,64 then note-off 62 -> slot 1 gate=0; next note-on 67 lands in slot 1; ages slot0=2, slot2=1, slot1=0.
- NUM_VOICES=4: note-ons 60,61,62,63,64 -> 64 steals slot 0 (oldest) with steal_pulse; then note-on 65 steals slot 1.
- Note-on 60 vel 80, then note-on 60 vel 20 -> same slot retriggered with vel=20 and a trig pulse; other slots untouched; note-on 60 vel 0 then releases it.
- panic asserted in LOOKUP of a note-on 70 -> all gates 0, note 70 never assigned, no trig, evt_ready=1 next cycle.
- rst_n low during COMMIT -> all outputs at reset values next edge; note-off 99 with no voice assigned -> no output change.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: event/state enums and note/velocity types shared by the MIDI receive path and voice allocator.
// Revision 1.0
`default_nettype none

package midi_pkg;

  typedef enum logic {
    EVT_NOTE_OFF = 1'b0,
    EVT_NOTE_ON  = 1'b1
  } evt_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

  typedef logic [6:0] note_t;
  typedef logic [6:0] vel_t;

endpackage

`default_nettype wire

// File: rtl/voice_search.sv
// voice_search: combinational lowest-index match/free search and oldest-slot lookup over the voice bank.
// Revision 1.0
`default_nettype none

module voice_search
  import midi_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]    gates_i,
  input  logic [7*NUM_VOICES-1:0]  notes_i,
  input  logic [VW*NUM_VOICES-1:0] ages_i,
  input  note_t                    key_i,
  output logic                     match_hit_o,
  output logic [VW-1:0]            match_idx_o,
  output logic                     free_hit_o,
  output logic [VW-1:0]            free_idx_o,
  output logic [VW-1:0]            oldest_idx_o
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    match_hit_o  = 1'b0;
    match_idx_o  = '0;
    free_hit_o   = 1'b0;
    free_idx_o   = '0;
    oldest_idx_o = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gates_i[i] && (notes_i[7*i +: 7] == key_i)) begin
        match_hit_o = 1'b1;
        match_idx_o = VW'(i);
      end
      if (!gates_i[i]) begin
        free_hit_o = 1'b1;
        free_idx_o = VW'(i);
      end
      if (gates_i[i] && (ages_i[VW*i +: VW] == VW'(NUM_VOICES - 1))) begin
        oldest_idx_o = VW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: assigns note-on/off events to voice slots with retrigger, free reuse and oldest-steal.
// Revision 1.0
`default_nettype none

module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    evt_valid,
  output logic                    evt_ready,
  input  logic                    evt_note_on,
  input  logic [6:0]              evt_note,
  input  logic [6:0]              evt_velocity,
  input  logic                    panic,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic                    steal_pulse
);

  alloc_state_t          state_q, state_d;
  evt_type_t             type_q, type_d;
  note_t                 enote_q, enote_d;
  vel_t                  evel_q, evel_d;
  logic                  match_hit_q, match_hit_d, free_hit_q, free_hit_d;
  logic [VW-1:0]         match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [VW-1:0]         oldest_idx_q, oldest_idx_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d, trig_q, trig_d;
  logic                  steal_q, steal_d;
  note_t                 notes_q [NUM_VOICES];
  note_t                 notes_d [NUM_VOICES];
  vel_t                  vels_q  [NUM_VOICES];
  vel_t                  vels_d  [NUM_VOICES];
  logic [VW-1:0]         ages_q  [NUM_VOICES];
  logic [VW-1:0]         ages_d  [NUM_VOICES];

  logic [VW*NUM_VOICES-1:0] ages_flat;
  logic                     s_match_hit, s_free_hit;
  logic [VW-1:0]            s_match_idx, s_free_idx, s_oldest_idx;
  logic [VW-1:0]            tgt_idx, tgt_age;
  logic                     alloc_free;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7]     = notes_q[g];
    assign voice_velocity[7*g +: 7] = vels_q[g];
    assign ages_flat[VW*g +: VW]    = ages_q[g];
  end

  voice_search #(.NUM_VOICES(NUM_VOICES)) u_search (
    .gates_i      (gate_q),
    .notes_i      (voice_note),
    .ages_i       (ages_flat),
    .key_i        (enote_q),
    .match_hit_o  (s_match_hit),
    .match_idx_o  (s_match_idx),
    .free_hit_o   (s_free_hit),
    .free_idx_o   (s_free_idx),
    .oldest_idx_o (s_oldest_idx)
  );

  assign evt_ready   = (state_q == IDLE);
  assign voice_gate  = gate_q;
  assign voice_trig  = trig_q;
  assign steal_pulse = steal_q;

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    enote_d      = enote_q;
    evel_d       = evel_q;
    match_hit_d  = match_hit_q;
    match_idx_d  = match_idx_q;
    free_hit_d   = free_hit_q;
    free_idx_d   = free_idx_q;
    oldest_idx_d = oldest_idx_q;
    gate_d       = gate_q;
    trig_d       = '0;
    steal_d      = 1'b0;
    notes_d      = notes_q;
    vels_d       = vels_q;
    ages_d       = ages_q;
    alloc_free   = !match_hit_q && free_hit_q;
    tgt_idx      = match_hit_q ? match_idx_q : (free_hit_q ? free_idx_q : oldest_idx_q);
    tgt_age      = ages_q[tgt_idx];

    case (state_q)
      IDLE: begin
        if (evt_valid) begin
          enote_d = evt_note;
          evel_d  = evt_velocity;
          type_d  = (evt_note_on && (evt_velocity != 7'd0)) ? EVT_NOTE_ON : EVT_NOTE_OFF;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        match_hit_d  = s_match_hit;
        match_idx_d  = s_match_idx;
        free_hit_d   = s_free_hit;
        free_idx_d   = s_free_idx;
        oldest_idx_d = s_oldest_idx;
        state_d      = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (type_q == EVT_NOTE_ON) begin
          // Free-slot allocation ages every active voice; retrigger/steal only those younger than the target.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_q[i] && (alloc_free || (ages_q[i] < tgt_age))) begin
              ages_d[i] = ages_q[i] + VW'(1);
            end
          end
          ages_d[tgt_idx]  = '0;
          gate_d[tgt_idx]  = 1'b1;
          notes_d[tgt_idx] = enote_q;
          vels_d[tgt_idx]  = evel_q;
          trig_d[tgt_idx]  = 1'b1;
          steal_d          = !match_hit_q && !free_hit_q;
        end else if (match_hit_q) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_q[i] && (ages_q[i] > ages_q[match_idx_q])) begin
              ages_d[i] = ages_q[i] - VW'(1);
            end
          end
          ages_d[match_idx_q] = '0;
          gate_d[match_idx_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (panic) begin
      state_d = IDLE;
      gate_d  = '0;
      trig_d  = '0;
      steal_d = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        ages_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      type_q       <= EVT_NOTE_OFF;
      enote_q      <= '0;
      evel_q       <= '0;
      match_hit_q  <= 1'b0;
      match_idx_q  <= '0;
      free_hit_q   <= 1'b0;
      free_idx_q   <= '0;
      oldest_idx_q <= '0;
      gate_q       <= '0;
      trig_q       <= '0;
      steal_q      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        notes_q[i] <= '0;
        vels_q[i]  <= '0;
        ages_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      enote_q      <= enote_d;
      evel_q       <= evel_d;
      match_hit_q  <= match_hit_d;
      match_idx_q  <= match_idx_d;
      free_hit_q   <= free_hit_d;
      free_idx_q   <= free_idx_d;
      oldest_idx_q <= oldest_idx_d;
      gate_q       <= gate_d;
      trig_q       <= trig_d;
      steal_q      <= steal_d;
      notes_q      <= notes_d;
      vels_q       <= vels_d;
      ages_q       <= ages_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed and random events checked against a recency-queue voice model.
// Revision 1.0
`default_nettype none

module tb_midi_voice_allocator;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           evt_valid = 1'b0;
  logic           evt_ready;
  logic           evt_note_on = 1'b0;
  logic [6:0]     evt_note = '0;
  logic [6:0]     evt_velocity = '0;
  logic           panic = 1'b0;
  logic [N-1:0]   voice_gate, voice_trig;
  logic [7*N-1:0] voice_note, voice_velocity;
  logic           steal_pulse;

  int checks = 0;
  int errors = 0;

  // Model: per-slot state plus a queue of active slots, most recently started first.
  logic       mg [N];
  logic [6:0] mn [N];
  logic [6:0] mv [N];
  int         order[$];

  midi_voice_allocator #(.NUM_VOICES(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_note_on    (evt_note_on),
    .evt_note       (evt_note),
    .evt_velocity   (evt_velocity),
    .panic          (panic),
    .voice_gate     (voice_gate),
    .voice_trig     (voice_trig),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .steal_pulse    (steal_pulse)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mg[i] = 1'b0; mn[i] = '0; mv[i] = '0;
    end
    order.delete();
  endtask

  task automatic model_panic();
    for (int i = 0; i < N; i++) mg[i] = 1'b0;
    order.delete();
  endtask

  task automatic drop_from_order(input int s);
    for (int k = 0; k < order.size(); k++) begin
      if (order[k] == s) begin
        order.delete(k);
        break;
      end
    end
  endtask

  task automatic model_evt(input bit on, input logic [6:0] n, input logic [6:0] v,
                           output logic [N-1:0] etrig, output logic esteal);
    int m = -1;
    int f = -1;
    int tgt;
    etrig  = '0;
    esteal = 1'b0;
    for (int i = 0; i < N; i++) if (mg[i] && mn[i] == n && m < 0) m = i;
    for (int i = 0; i < N; i++) if (!mg[i] && f < 0) f = i;
    if (on && v != 0) begin
      if (m >= 0) begin
        tgt = m;
        drop_from_order(tgt);
      end else if (f >= 0) begin
        tgt = f;
      end else begin
        tgt = order[order.size() - 1];
        void'(order.pop_back());
        esteal = 1'b1;
      end
      order.push_front(tgt);
      mg[tgt] = 1'b1; mn[tgt] = n; mv[tgt] = v;
      etrig[tgt] = 1'b1;
    end else if (m >= 0) begin
      mg[m] = 1'b0;
      drop_from_order(m);
    end
  endtask

  task automatic chk_voices(input string tag);
    logic [N-1:0]   eg;
    logic [7*N-1:0] en, ev;
    for (int i = 0; i < N; i++) begin
      eg[i] = mg[i];
      en[7*i +: 7] = mn[i];
      ev[7*i +: 7] = mv[i];
    end
    chk({tag, "_gate"}, 64'(voice_gate), 64'(eg));
    chk({tag, "_note"}, 64'(voice_note), 64'(en));
    chk({tag, "_vel"},  64'(voice_velocity), 64'(ev));
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic do_evt(input bit on, input logic [6:0] n, input logic [6:0] v, input string tag);
    logic [N-1:0] etrig;
    logic         esteal;
    int w = 0;
    while (!evt_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready_pre"}, 64'(evt_ready), 64'(1));
    evt_valid = 1'b1; evt_note_on = on; evt_note = n; evt_velocity = v;
    @(posedge clk); #1;
    evt_valid = 1'b0;
    model_evt(on, n, v, etrig, esteal);
    chk({tag, "_ready_t0"}, 64'(evt_ready), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_ready_t1"}, 64'(evt_ready), 64'(0));
    chk({tag, "_trig_t1"}, 64'(voice_trig), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_ready_t2"}, 64'(evt_ready), 64'(1));
    chk({tag, "_trig_t2"}, 64'(voice_trig), 64'(etrig));
    chk({tag, "_steal_t2"}, 64'(steal_pulse), 64'(esteal));
    chk_voices(tag);
    @(posedge clk); #1;
    chk({tag, "_trig_t3"}, 64'(voice_trig), 64'(0));
    chk({tag, "_steal_t3"}, 64'(steal_pulse), 64'(0));
    @(negedge clk);
  endtask

  task automatic do_panic(input string tag);
    panic = 1'b1;
    @(posedge clk); #1;
    panic = 1'b0;
    model_panic();
    chk({tag, "_ready"}, 64'(evt_ready), 64'(1));
    chk({tag, "_trig"}, 64'(voice_trig), 64'(0));
    chk_voices(tag);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(evt_ready), 64'(1));
    chk("rst_trig", 64'(voice_trig), 64'(0));
    chk("rst_steal", 64'(steal_pulse), 64'(0));
    chk_voices("rst");
    @(negedge clk);
    rst_n = 1'b1;

    do_evt(1'b1, 7'd60, 7'd100, "first_on");

    do_panic("pan_a");
    do_evt(1'b1, 7'd60, 7'd90, "age_on60");
    do_evt(1'b1, 7'd62, 7'd91, "age_on62");
    do_evt(1'b1, 7'd64, 7'd92, "age_on64");
    do_evt(1'b0, 7'd62, 7'd0,  "age_off62");
    do_evt(1'b1, 7'd67, 7'd93, "age_on67");
    do_evt(1'b1, 7'd68, 7'd94, "age_on68");
    do_evt(1'b1, 7'd69, 7'd95, "age_steal69");
    do_evt(1'b1, 7'd70, 7'd96, "age_steal70");

    do_panic("pan_b");
    do_evt(1'b1, 7'd60, 7'd80, "rt_on80");
    do_evt(1'b1, 7'd61, 7'd50, "rt_on61");
    do_evt(1'b1, 7'd60, 7'd20, "rt_on20");
    do_evt(1'b1, 7'd60, 7'd0,  "rt_vel0");
    do_evt(1'b0, 7'd60, 7'd0,  "rt_dupoff");

    // Panic while the note-on 70 is in LOOKUP.
    evt_valid = 1'b1; evt_note_on = 1'b1; evt_note = 7'd70; evt_velocity = 7'd99;
    @(posedge clk); #1;
    evt_valid = 1'b0;
    @(negedge clk);
    panic = 1'b1;
    @(posedge clk); #1;
    panic = 1'b0;
    model_panic();
    chk("plk_ready", 64'(evt_ready), 64'(1));
    chk_voices("plk_a");
    @(posedge clk); #1;
    chk("plk_trig", 64'(voice_trig), 64'(0));
    chk("plk_steal", 64'(steal_pulse), 64'(0));
    chk_voices("plk_b");
    @(negedge clk);

    for (int k = 0; k < 5; k++) do_evt(1'b1, 7'(60 + k), 7'(30 + k), "st_on");
    do_evt(1'b1, 7'd65, 7'd40, "st_on65");

    // Reset while an event sits in COMMIT.
    evt_valid = 1'b1; evt_note_on = 1'b1; evt_note = 7'd80; evt_velocity = 7'd81;
    @(posedge clk); #1;
    evt_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("rstc_ready", 64'(evt_ready), 64'(1));
    chk("rstc_trig", 64'(voice_trig), 64'(0));
    chk("rstc_steal", 64'(steal_pulse), 64'(0));
    chk_voices("rstc");
    @(negedge clk);
    rst_n = 1'b1;
    do_evt(1'b0, 7'd99, 7'd0, "off99");

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 12) == 0) begin
        do_panic("rnd_panic");
      end else begin
        do_evt($urandom_range(0, 2) != 0, 7'(60 + $urandom_range(0, 5)),
               ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127)), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
